vga_vram_arbiter: RTL

//  Shares the single-port video RAM between CPU VGA-opcode pixel writes and the display scan-out reader.
//  CPU writes are buffered in a small FIFO and drained in cycles the reader leaves idle. The reader always wins.

---
 rtl/vga_vram_arbiter_pkg.sv | 17 +
 rtl/vga_vram_arbiter_wr_fifo.sv | 48 ++++
 rtl/vga_vram_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_pkg.sv
// Shared FSM encodings and colour constants for the VRAM arbiter.
// S_CLEAR exists only when VGA_VRAM_CLEAR_EN is defined.
package vga_vram_arbiter_pkg;

`ifdef VGA_VRAM_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_CLEAR = 2'd2} arb_state_e;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} arb_state_e;
`endif

  localparam logic [7:0] COLOR_BLACK = 8'h00;
  localparam logic [7:0] COLOR_RED   = 8'hE0;
  localparam logic [7:0] COLOR_GREEN = 8'h1C;
  localparam logic [7:0] COLOR_BLUE  = 8'h03;
  localparam logic [7:0] COLOR_WHITE = 8'hFF;

endpackage

// File: rtl/vga_vram_arbiter_wr_fifo.sv
// Synchronous CPU pixel-write FIFO; callers guarantee no push when full, no pop when empty.
module vram_wr_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads always win, buffered CPU writes drain in idle cycles.
// Define VGA_VRAM_CLEAR_EN to add the full-screen clear sweep (iClear/iClear_Color/oClearing).
module vga_vram_arbiter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int COLOR_W = 8,
  parameter int COORD_W = 8,
  parameter int DEPTH   = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iCPU_WrEn,
  input  logic [COORD_W-1:0]   iCPU_Col,
  input  logic [COORD_W-1:0]   iCPU_Row,
  input  logic [COLOR_W-1:0]   iCPU_Color,
  output logic                 oCPU_Stall,
  input  logic                 iRd_Req,
  input  logic [COORD_W-1:0]   iRd_Col,
  input  logic [COORD_W-1:0]   iRd_Row,
  output logic [COLOR_W-1:0]   oRd_Color,
  output logic                 oRd_Valid,
  output logic                 oVRAM_WrEn,
  output logic [2*COORD_W-1:0] oVRAM_Addr,
  output logic [COLOR_W-1:0]   oVRAM_WrData,
  input  logic [COLOR_W-1:0]   iVRAM_RdData,
  output logic                 oBusy
`ifdef VGA_VRAM_CLEAR_EN
  ,
  input  logic                 iClear,
  input  logic [COLOR_W-1:0]   iClear_Color,
  output logic                 oClearing
`endif
);
  localparam int AW = 2 * COORD_W;
  localparam int FW = AW + COLOR_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [FW-1:0] head;
  arb_state_e    state_q, state_d;
  logic [1:0]    rd_vld_q;
  logic [COLOR_W-1:0] rd_color_q;

  assign push       = iCPU_WrEn && !full;
  assign oCPU_Stall = full;

  vram_wr_fifo #(.W(FW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .wdata ({iCPU_Row, iCPU_Col, iCPU_Color}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef VGA_VRAM_CLEAR_EN
  logic               clr_pend_q, clr_pend_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic [AW-1:0]      clr_addr_q, clr_addr_d;

  assign oClearing = (state_q == S_CLEAR);
  assign oBusy     = !empty || clr_pend_q || oClearing;
`else
  assign oBusy     = !empty;
`endif

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    oVRAM_WrEn   = 1'b0;
    oVRAM_Addr   = {iRd_Row, iRd_Col};
    oVRAM_WrData = head[COLOR_W-1:0];
`ifdef VGA_VRAM_CLEAR_EN
    clr_pend_d  = clr_pend_q;
    clr_color_d = clr_color_q;
    clr_addr_d  = clr_addr_q;
    if (iClear && !clr_pend_q && state_q != S_CLEAR) begin
      clr_pend_d  = 1'b1;
      clr_color_d = iClear_Color;
    end
`endif
    case (state_q)
      S_IDLE, S_DRAIN: begin
        pop = !iRd_Req && !empty;
        if (pop) begin
          oVRAM_WrEn = 1'b1;
          oVRAM_Addr = head[FW-1:COLOR_W];
        end
        if (state_q == S_IDLE && !empty) state_d = S_DRAIN;
        if (state_q == S_DRAIN && pop && !push && count == CW'(1)) state_d = S_IDLE;
`ifdef VGA_VRAM_CLEAR_EN
        // Waiting for an empty FIFO makes the clear erase every earlier CPU write.
        if (state_q == S_IDLE && clr_pend_q && empty) begin
          state_d    = S_CLEAR;
          clr_pend_d = 1'b0;
        end
`endif
      end
`ifdef VGA_VRAM_CLEAR_EN
      S_CLEAR: begin
        if (!iRd_Req) begin
          oVRAM_WrEn   = 1'b1;
          oVRAM_Addr   = clr_addr_q;
          oVRAM_WrData = clr_color_q;
          clr_addr_d   = clr_addr_q + AW'(1);
          if (&clr_addr_q) state_d = empty ? S_IDLE : S_DRAIN;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      rd_vld_q   <= '0;
      rd_color_q <= '0;
`ifdef VGA_VRAM_CLEAR_EN
      clr_pend_q  <= 1'b0;
      clr_color_q <= '0;
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_vld_q <= {rd_vld_q[0], iRd_Req};
      if (rd_vld_q[0]) rd_color_q <= iVRAM_RdData;
`ifdef VGA_VRAM_CLEAR_EN
      clr_pend_q  <= clr_pend_d;
      clr_color_q <= clr_color_d;
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

  assign oRd_Valid = rd_vld_q[1];
  assign oRd_Color = rd_color_q;
endmodule
